z16_dmem_arbiter: RTL and testbench

- Shares the single-port Z16 data memory between two requesters: port 0 (CPU load/store path) and port 1 (DMA/debug loader).
- Port 0 has fixed priority. A wait counter forces a port 1 grant after MAX_WAIT consecutive blocked cycles, so port 1 cannot starve.
- Sits between the requesters and the data memory. Returns read data after a fixed, parameterised memory latency.

---
 rtl/z16_dmem_arbiter.sv | 68 ++++++
 tb/tb_z16_dmem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/z16_dmem_arbiter.sv
// z16_dmem_arbiter: shares the Z16 data memory between CPU (port 0) and DMA/debug (port 1) with a starvation guard
module z16_dmem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req0,
   input  logic              i_we0,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [DATA_W-1:0] i_wdata0,
   output logic              o_gnt0,
   input  logic              i_req1,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic              o_gnt1,
   output logic [1:0]        o_rvalid,
   output logic [DATA_W-1:0] o_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_re,
   input  logic [DATA_W-1:0] i_mem_rdata
);
   logic [3:0]        wait_cnt;
   logic              force1;
   logic [RD_LAT-1:0] tag_v;
   logic [RD_LAT-1:0] tag_p;

   assign force1 = (wait_cnt == 4'(MAX_WAIT)) && i_req1;

   // Grant and memory-side mux; everything is held at zero while reset is asserted
   always_comb begin
      o_gnt1      = i_rst_n && (force1 || (i_req1 && !i_req0));
      o_gnt0      = i_rst_n && i_req0 && !force1;
      o_mem_addr  = o_gnt1 ? i_addr1 : o_gnt0 ? i_addr0 : '0;
      o_mem_wdata = o_gnt1 ? i_wdata1 : o_gnt0 ? i_wdata0 : '0;
      o_mem_we    = (o_gnt0 && i_we0) || (o_gnt1 && i_we1);
      o_mem_re    = (o_gnt0 && !i_we0) || (o_gnt1 && !i_we1);
   end

   // Count consecutive cycles port 1 is blocked, saturating at the forcing threshold
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         wait_cnt <= '0;
      else if (!i_req1 || o_gnt1)
         wait_cnt <= '0;
      else if (wait_cnt != 4'(MAX_WAIT))
         wait_cnt <= wait_cnt + 4'd1;
   end

   // Read tag pipeline: {valid, port} tracks each read until its data returns from memory
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tag_v <= '0;
         tag_p <= '0;
      end else begin
         tag_v <= RD_LAT'({tag_v, o_mem_re});
         tag_p <= RD_LAT'({tag_p, o_gnt1});
      end
   end

   assign o_rvalid = {tag_v[RD_LAT-1] && tag_p[RD_LAT-1], tag_v[RD_LAT-1] && !tag_p[RD_LAT-1]};
   assign o_rdata  = (|o_rvalid) ? i_mem_rdata : '0;
endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// tb_z16_dmem_arbiter: randomized and directed checks of z16_dmem_arbiter against a transaction-level model
module tb_z16_dmem_arbiter;
   localparam int LAT = 2;
   localparam int MW  = 4;

   typedef struct {
      int          cyc;
      int          port;
      logic [15:0] data;
   } ev_t;

   logic        clk, rst_n;
   logic        req0, we0, gnt0, req1, we1, gnt1;
   logic [15:0] addr0, wdata0, addr1, wdata1;
   logic [1:0]  rvalid;
   logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;

   logic [15:0] mem [65536];
   logic [15:0] ref_mem [65536];
   logic [15:0] rd_pipe [LAT];

   logic        p_req [2];
   logic        p_we [2];
   logic [15:0] p_addr [2];
   logic [15:0] p_wdata [2];
   int          prob [2];
   ev_t         q [$];
   int          mw, cyc_n, n_cmp, n_err;
   logic        last_rd0;

   z16_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT), .MAX_WAIT(MW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0), .o_gnt0(gnt0),
      .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .o_gnt1(gnt1),
      .o_rvalid(rvalid), .o_rdata(rdata),
      .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .o_mem_re(mem_re),
      .i_mem_rdata(mem_rdata)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      rd_pipe[0] <= mem_re ? mem[mem_addr] : 16'h0;
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
      end
   endtask

   task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
      p_req[p] = 1; p_we[p] = w; p_addr[p] = a; p_wdata[p] = d;
   endtask

   task automatic drive();
      req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
      req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
   endtask

   task automatic cycle();
      logic       f1, eg0, eg1, ew;
      logic [1:0] erv;
      logic [15:0] erd, ea, ed;
      int         gp;
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         if (!p_req[i] && $urandom_range(99) < prob[i])
            issue(i, 1'($urandom_range(1)), 16'($urandom_range(63)), 16'($urandom));
      drive();
      #1;
      f1  = (mw == MW) && p_req[1];
      eg1 = f1 || (p_req[1] && !p_req[0]);
      eg0 = p_req[0] && !f1;
      gp  = eg1 ? 1 : 0;
      ew  = p_we[gp];
      ea  = (eg0 || eg1) ? p_addr[gp] : 16'h0;
      ed  = (eg0 || eg1) ? p_wdata[gp] : 16'h0;
      chk("gnt0", gnt0, eg0);
      chk("gnt1", gnt1, eg1);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
      chk("mem_we", mem_we, (eg0 || eg1) && ew);
      chk("mem_re", mem_re, (eg0 || eg1) && !ew);
      erv = 2'b00;
      erd = 16'h0;
      foreach (q[k])
         if (q[k].cyc == cyc_n) begin
            erv[q[k].port] = 1'b1;
            erd = q[k].data;
         end
      while (q.size() > 0 && q[0].cyc <= cyc_n) void'(q.pop_front());
      chk("rvalid", rvalid, erv);
      if (erv != 2'b00) chk("rdata", rdata, erd);
      @(posedge clk);
      last_rd0 = eg0 && !ew;
      if (eg0 || eg1) begin
         if (ew) ref_mem[p_addr[gp]] = p_wdata[gp];
         else q.push_back('{cyc: cyc_n + LAT, port: gp, data: ref_mem[p_addr[gp]]});
         p_req[gp] = 0;
      end
      mw = (p_req[1] && !eg1) ? ((mw < MW) ? mw + 1 : MW) : 0;
      cyc_n++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      n_cmp = 0; n_err = 0; mw = 0; cyc_n = 0; last_rd0 = 0;
      prob[0] = 0; prob[1] = 0;
      for (int i = 0; i < 2; i++) begin
         p_req[i] = 0; p_we[i] = 0; p_addr[i] = 0; p_wdata[i] = 0;
      end
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[16'h0010] = 16'hBEEF;
      ref_mem[16'h0010] = 16'hBEEF;
      for (int k = 0; k < LAT; k++) rd_pipe[k] = 0;
      rst_n = 0;
      req0 = 1; we0 = 0; addr0 = 16'h0010; wdata0 = 16'h5555;
      req1 = 1; we1 = 1; addr1 = 16'h0020; wdata1 = 16'hAAAA;
      #2;
      chk("rst_gnt", {gnt1, gnt0}, 2'b00);
      chk("rst_mem", {mem_we, mem_re, mem_addr, mem_wdata}, 34'h0);
      chk("rst_rv", {rvalid, rdata}, 18'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      drive();
      // single read on port 0
      issue(0, 0, 16'h0010, 16'h0);
      run(LAT + 2);
      // write then read on port 1
      issue(1, 1, 16'h0020, 16'h1234);
      cycle();
      issue(1, 0, 16'h0020, 16'h0);
      run(LAT + 2);
      // pipelined alternation
      issue(0, 0, 16'h0002, 16'h0);
      cycle();
      issue(1, 0, 16'h0004, 16'h0);
      cycle();
      issue(0, 0, 16'h0006, 16'h0);
      run(LAT + 3);
      // starvation guard with both ports streaming
      prob[0] = 100; prob[1] = 100;
      run(22);
      // reset while a port 0 read is in flight
      prob[0] = 0;
      for (int i = 0; i < 12 && !last_rd0; i++) begin
         if (!p_req[0]) issue(0, 0, 16'h0010, 16'h0);
         cycle();
      end
      chk("rst_setup", last_rd0, 1'b1);
      prob[0] = 100;
      @(negedge clk);
      rst_n = 0;
      if (!p_req[0]) issue(0, 0, 16'h0010, 16'h0);
      drive();
      #1;
      chk("rst_mid_gnt", {gnt1, gnt0}, 2'b00);
      chk("rst_mid_mem", {mem_we, mem_re, mem_addr, mem_wdata}, 34'h0);
      chk("rst_mid_rv", {rvalid, rdata}, 18'h0);
      @(posedge clk);
      #1;
      chk("rst_hold_rv", {rvalid, rdata}, 18'h0);
      rst_n = 1;
      q.delete();
      mw = 0;
      run(16);
      // port 1 idle while port 0 streams
      prob[0] = 0; prob[1] = 0;
      run(8);
      prob[0] = 100;
      run(20);
      // randomized traffic
      for (int blk = 0; blk < 40; blk++) begin
         prob[0] = $urandom_range(100);
         prob[1] = $urandom_range(100);
         run(50);
      end
      prob[0] = 0; prob[1] = 0;
      run(LAT + 4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
